// File: rtl/siso_4bit_shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// siso_pkg
// Shared constants for the serial-in/serial-out shift register slice.
//
// Contents:
//   SISO_DEFAULT_WIDTH - stage count used when the top is instantiated
//                        without overriding WIDTH.
//
// Optional feature macro used by the top level: SISO_PARALLEL_LOAD_EN
// -----------------------------------------------------------------------------
package siso_pkg;

  // Default number of flip-flop stages, which is also the din-to-dout latency.
  localparam int SISO_DEFAULT_WIDTH = 4;

  // Smallest stage count for which a serial chain (stage 0 feeding stage 1 ...)
  // makes sense; the top refuses to elaborate below this.
  localparam int SISO_MIN_WIDTH = 2;

endpackage : siso_pkg

// File: rtl/siso_4bit_shift_reg_dff.sv
// -----------------------------------------------------------------------------
// dff_async_rn
// Single D flip-flop with asynchronous, active-low clear. This is the one
// storage primitive of the shift register; the top chains WIDTH of them.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low clear, forces q to 0 immediately
//   d     - data captured on each rising clk edge while rst_n is high
//   q     - registered output
// -----------------------------------------------------------------------------
module dff_async_rn (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // Clear wins over the clock so a stage empties the moment rst_n drops,
  // whether or not an edge is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule : dff_async_rn

// File: rtl/siso_4bit_shift_reg.sv
// -----------------------------------------------------------------------------
// siso_4bit_shift_reg
// Serial-in/serial-out shift register built structurally from a chain of
// dff_async_rn flops. A bit presented on din is delayed by WIDTH clock edges
// before it leaves on dout; every stage is also visible on the q tap bus.
//
// Parameters:
//   WIDTH  - number of stages (>= 2), default siso_pkg::SISO_DEFAULT_WIDTH
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears every stage at once
//   din    - serial input, sampled into stage 0 on each rising edge
//   dout   - serial output, the oldest stage q[WIDTH-1] (no extra register)
//   q      - parallel view, q[0] newest bit, q[WIDTH-1] oldest bit
//
// Optional feature (macro SISO_PARALLEL_LOAD_EN):
//   load   - when high at a rising edge, every stage takes pdata instead of
//            shifting; reset still overrides it
//   pdata  - parallel load value, drains out of dout MSB first afterwards
// Without the macro neither port exists and the block is a pure SISO chain.
// -----------------------------------------------------------------------------
module siso_4bit_shift_reg
  import siso_pkg::*;
#(
  parameter int WIDTH = SISO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SISO_PARALLEL_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] pdata,
`endif
  input  logic             din,
  output logic             dout,
  output logic [WIDTH-1:0] q
);

  // Stage contents and the value each stage will capture at the next edge.
  logic [WIDTH-1:0] stage_q;
  logic [WIDTH-1:0] stage_d;

  // Value arriving at each stage along the serial path: din for stage 0,
  // the previous stage's output for every other stage.
  logic [WIDTH-1:0] serialIn;

  // A one-stage "chain" would have no stage-to-stage path at all, so such a
  // configuration is rejected while the design is elaborated.
  if (WIDTH < SISO_MIN_WIDTH) begin : gWidthCheck
    $error("siso_4bit_shift_reg: WIDTH must be at least %0d", SISO_MIN_WIDTH);
  end

  // Build the chain one stage at a time: pick the serial source, optionally
  // put the parallel-load mux in front of it, then register it.
  for (genvar i = 0; i < WIDTH; i++) begin : gStage

    if (i == 0) begin : gHead
      assign serialIn[i] = din;
    end else begin : gLink
      assign serialIn[i] = stage_q[i-1];
    end

`ifdef SISO_PARALLEL_LOAD_EN
    // A load edge replaces the shift for that edge only; the next edge with
    // load low resumes shifting from the loaded value.
    assign stage_d[i] = load ? pdata[i] : serialIn[i];
`else
    assign stage_d[i] = serialIn[i];
`endif

    dff_async_rn uStageFf (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (stage_d[i]),
      .q     (stage_q[i])
    );
  end : gStage

  // The serial output is simply the oldest stage, so the latency is exactly
  // WIDTH edges with no additional output flop.
  assign q    = stage_q;
  assign dout = stage_q[WIDTH-1];

endmodule : siso_4bit_shift_reg

// File: tb/tb_siso_4bit_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_siso_4bit_shift_reg
// Directed, table-driven bench for siso_4bit_shift_reg. A 4-stage instance is
// exercised with a vector table and hand-written reset sequences; an 8-stage
// instance sharing clock, reset and din is used for the latency check.
// Optional feature macro honoured: SISO_PARALLEL_LOAD_EN
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_siso_4bit_shift_reg;

  // Clock, shared reset and shared serial input.
  logic       clk;
  logic       rst_n;
  logic       din;
  logic       dout4;
  logic [3:0] q4;
  logic       dout8;
  logic [7:0] q8;
`ifdef SISO_PARALLEL_LOAD_EN
  logic       load;
  logic [3:0] pdata4;
  logic [7:0] pdata8;
`endif

  int testsRun;
  int testsFailed;

  // One row of the shift-pattern table: bit driven for one cycle and the
  // state expected just after the following rising edge.
  typedef struct {
    logic       din;
    logic [3:0] expQ;
    logic       expDout;
  } vector_t;

  vector_t vectors [6];

  // Rising edges at t = 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  siso_4bit_shift_reg #(.WIDTH(4)) uDut4 (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SISO_PARALLEL_LOAD_EN
    .load  (load),
    .pdata (pdata4),
`endif
    .din   (din),
    .dout  (dout4),
    .q     (q4)
  );

  siso_4bit_shift_reg #(.WIDTH(8)) uDut8 (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SISO_PARALLEL_LOAD_EN
    .load  (load),
    .pdata (pdata8),
`endif
    .din   (din),
    .dout  (dout8),
    .q     (q8)
  );

  // Drive one serial bit, let one rising edge capture it, sample 1ns later.
  task automatic applyStimulus(input logic bitIn);
    din = bitIn;
    @(posedge clk);
    #1;
  endtask

  // Compare a tap bus and a serial output against expected values.
  task automatic checkOutput(input string name,
                             input logic [7:0] actQ, input logic [7:0] expQ,
                             input logic actDout, input logic expDout);
    testsRun++;
    if (actQ !== expQ) begin
      testsFailed++;
      $display("[TB] FAIL %s q: got %b expected %b", name, actQ, expQ);
    end
    testsRun++;
    if (actDout !== expDout) begin
      testsFailed++;
      $display("[TB] FAIL %s dout: got %b expected %b", name, actDout, expDout);
    end
  endtask

  // Pulse reset between clock edges (called just after a sample point).
  task automatic pulseReset();
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    din         = 1'b0;
    rst_n       = 1'b0;
`ifdef SISO_PARALLEL_LOAD_EN
    load        = 1'b0;
    pdata4      = '0;
    pdata8      = '0;
`endif

    vectors[0] = '{din: 1'b1, expQ: 4'b0001, expDout: 1'b0};
    vectors[1] = '{din: 1'b0, expQ: 4'b0010, expDout: 1'b0};
    vectors[2] = '{din: 1'b1, expQ: 4'b0101, expDout: 1'b0};
    vectors[3] = '{din: 1'b1, expQ: 4'b1011, expDout: 1'b1};
    vectors[4] = '{din: 1'b1, expQ: 4'b0111, expDout: 1'b0};
    vectors[5] = '{din: 1'b1, expQ: 4'b1111, expDout: 1'b1};

    // Reset state before any clock edge has occurred.
    #2;
    checkOutput("reset4", {4'b0, q4}, 8'h00, dout4, 1'b0);
    checkOutput("reset8", q8, 8'h00, dout8, 1'b0);
    #1 rst_n = 1'b1;

    // Shift pattern 1,0,1,1 then held at 1.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vectors[i].din);
      checkOutput($sformatf("pattern%0d", i), {4'b0, q4}, {4'b0, vectors[i].expQ},
                  dout4, vectors[i].expDout);
    end

    // Single pulse latency on both widths, starting from a cleared chain.
    pulseReset();
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(k == 1);
      checkOutput($sformatf("latency4_e%0d", k), {4'b0, q4},
                  (k <= 4) ? (8'h01 << (k - 1)) : 8'h00, dout4, k == 4);
      checkOutput($sformatf("latency8_e%0d", k), q8,
                  (k <= 8) ? (8'h01 << (k - 1)) : 8'h00, dout8, k == 8);
    end

    // Mid-stream reset: load 1011, then clear between edges with no edge.
    pulseReset();
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("preload1011", {4'b0, q4}, 8'h0B, dout4, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncClear", {4'b0, q4}, 8'h00, dout4, 1'b0);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1);
    checkOutput("afterClear1", {4'b0, q4}, 8'h01, dout4, 1'b0);
    applyStimulus(1'b0);
    checkOutput("afterClear2", {4'b0, q4}, 8'h02, dout4, 1'b0);

    // Reset held low across a rising edge with din high: nothing is captured.
    #1 rst_n = 1'b0;
    applyStimulus(1'b1);
    checkOutput("resetOverClock", {4'b0, q4}, 8'h00, dout4, 1'b0);
    #1 rst_n = 1'b1;

`ifdef SISO_PARALLEL_LOAD_EN
    // Parallel load 1001, then drain it MSB first with din low.
    pulseReset();
    applyStimulus(1'b1);
    load   = 1'b1;
    pdata4 = 4'b1001;
    applyStimulus(1'b0);
    checkOutput("load1001", {4'b0, q4}, 8'h09, dout4, 1'b1);
    load = 1'b0;
    applyStimulus(1'b0);
    checkOutput("drain1", {4'b0, q4}, 8'h02, dout4, 1'b0);
    applyStimulus(1'b0);
    checkOutput("drain2", {4'b0, q4}, 8'h04, dout4, 1'b0);
    applyStimulus(1'b0);
    checkOutput("drain3", {4'b0, q4}, 8'h08, dout4, 1'b1);

    // Reset overrides a pending load.
    load = 1'b1;
    #1 rst_n = 1'b0;
    applyStimulus(1'b0);
    checkOutput("resetOverLoad", {4'b0, q4}, 8'h00, dout4, 1'b0);
    load = 1'b0;
    #1 rst_n = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule : tb_siso_4bit_shift_reg

// File: doc/siso_4bit_shift_reg.md
Name: siso_4bit_shift_reg

Overview:
- Serial-in/serial-out shift register, default 4 stages, built structurally as a chain of D flip-flops.
- Delays a 1-bit serial stream by WIDTH clock cycles.
- Exposes all stage contents on a parallel tap bus for debug and observation.
- Used as a serial delay line or a bit-stream capture element in the datapath.

Parameters:
- WIDTH, 4, number of flip-flop stages (≥2); sets the q width and the din-to-dout latency.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low; clears all stages
- din  input  1  serial data in; sampled into stage 0 on each rising clk edge
- dout  output  1  serial data out; equals q[WIDTH-1]
- q  output  WIDTH  parallel view of all stages; q[0] is the newest bit, q[WIDTH-1] the oldest

Interface decision (already decided): one clock (clk); reset rst_n is asynchronous and active-low.

Behaviour:
- Reset: rst_n low clears q to all zeros and dout to 0 immediately, without waiting for a clock edge. Reset takes priority over clocking.
- Release of rst_n is synchronous in effect: the first shift occurs at the first rising clk edge with rst_n high.
- Shift on every rising clk edge (no enable):
  - q[0] <= din
  - q[i] <= q[i-1] for i = 1..WIDTH-1
  - Equivalent to q <= {q[WIDTH-2:0], din}.
- dout is combinational from q[WIDTH-1], with no extra register.
- Latency:
  - A bit sampled at edge k appears on q[0] after edge k.
  - The same bit appears on dout after edge k+WIDTH-1, i.e. it is visible on dout during cycle WIDTH counting the sampling edge as 1.
- Oldest bit is discarded at each edge; there is no wrap-around.
- Reset mid-stream: all in-flight bits are lost; the register restarts from zero.
- din must be stable around the clk edge. No X-propagation handling beyond standard flop semantics.
- Outputs are undefined before the first reset assertion; benches must apply reset first.

Optional Feature:
- Macro SISO_PARALLEL_LOAD_EN.
- Defined:
  - Adds input load (1 bit) and input pdata (WIDTH bits).
  - On a rising edge with load=1, q <= pdata and the shift is suppressed for that edge.
  - Asynchronous reset still overrides load.
  - Subsequent edges with load=0 shift as normal, so pdata drains out through dout, MSB first.
- Undefined: neither port exists; behaviour is pure SISO as specified above.

Decomposition:
- Shared package siso_pkg: localparam default width constant SISO_DEFAULT_WIDTH=4. No typedefs required.
- One sub-module, dff_async_rn:
  - Ports: clk, rst_n, d, q.
  - Single D flop with asynchronous active-low clear.
  - Top instantiates WIDTH copies in a generate chain.
  - With SISO_PARALLEL_LOAD_EN defined, a 2:1 mux selecting pdata[i] vs. the serial input sits in front of each d.

Test Plan (clock period 10, rising edges at t=5, 15, 25, …; rst_n pulsed low then released before t=0):
- Reset: rst_n low at any time → q=0000 and dout=0 immediately. rst_n low between clock edges clears without a clk edge.
- Pattern shift: din=1,0,1,1 applied for one cycle each starting t=0, then held at 1.
  - After edges at t=5/15/25/35/45/55: q = 0001, 0010, 0101, 1011, 0111, 1111.
  - dout = 0, 0, 0, 1, 0, 1.
- Latency: single 1 pulse on din with din=0 otherwise → dout high for exactly one cycle, WIDTH-1 edges after the sampling edge. Recheck with WIDTH=8.
- Reset mid-stream: load q=1011, assert rst_n low between edges → q=0000 at once. Next edges shift from zero.
- Parallel load (SISO_PARALLEL_LOAD_EN): load=1, pdata=1001 at one edge → q=1001. Then load=0, din=0 → dout sequence 1, 0, 0, 1.
